// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared alarm clock and responder types and helpers
package alarm_pkg;

  // Responder FSM: user-facing side of an alarm event.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    HOLDOFF = 2'd3
  } resp_state_t;

  // Alarm clock core modes, shared by the core and its neighbours.
  typedef enum logic [1:0] {
    CLK_RUN        = 2'd0,
    CLK_SET_TIME   = 2'd1,
    CLK_SET_ALARM  = 2'd2,
    CLK_ALARM_EDIT = 2'd3
  } clk_mode_t;

  localparam int unsigned DEF_SNOOZE_SECONDS = 300;
  localparam int unsigned DEF_MAX_SNOOZES    = 3;
  localparam int unsigned DEF_RING_TIMEOUT   = 60;

  // Width of an unsigned counter that must hold 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alarm_responder_if.sv
// rtl/alarm_responder_if.sv - front-panel and core signals of the alarm responder
interface alarm_responder_if #(
  parameter int unsigned MAX_SNOOZES = 3
);
  import alarm_pkg::*;

  localparam int unsigned SC_W = cnt_w(MAX_SNOOZES);

  logic            tick_1hz;
  logic            alarm_ringing;
  logic            snooze_btn;
  logic            dismiss_btn;
  logic            buzzer;
  logic            snoozing;
  logic            alarm_ack;
  logic            timed_out;
  logic [SC_W-1:0] snooze_count;

  // Drives the responder: timebase, alarm core and buttons.
  modport master (
    output tick_1hz, alarm_ringing, snooze_btn, dismiss_btn,
    input  buzzer, snoozing, alarm_ack, timed_out, snooze_count
  );

  // The responder itself.
  modport slave (
    input  tick_1hz, alarm_ringing, snooze_btn, dismiss_btn,
    output buzzer, snoozing, alarm_ack, timed_out, snooze_count
  );

endinterface

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - rising-edge detector for a synchronised button level
module btn_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // One-cycle history of the button level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  // A held button produces exactly one rise.
  assign rise = level & ~level_q;

endmodule

// File: rtl/alarm_responder.sv
// rtl/alarm_responder.sv - buzzer, snooze and dismiss handling for a ringing alarm
module alarm_responder
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
  parameter int unsigned MAX_SNOOZES    = DEF_MAX_SNOOZES,
  parameter int unsigned RING_TIMEOUT   = DEF_RING_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  alarm_responder_if.slave   resp_if
);

  localparam int unsigned RING_W = cnt_w(RING_TIMEOUT);
  localparam int unsigned SNZ_W  = cnt_w(SNOOZE_SECONDS);
  localparam int unsigned SC_W   = cnt_w(MAX_SNOOZES);

  localparam logic [RING_W-1:0] RING_LIMIT = RING_W'(RING_TIMEOUT);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD   = SNZ_W'(SNOOZE_SECONDS);
  localparam logic [SC_W-1:0]   SNZ_MAX    = SC_W'(MAX_SNOOZES);

  resp_state_t       state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d, ring_inc;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [SC_W-1:0]   snooze_count_q, snooze_count_d;
  logic              buzzer_q, buzzer_d;
  logic              snoozing_q, snoozing_d;
  logic              alarm_ack_q, alarm_ack_d;
  logic              timed_out_q, timed_out_d;
  logic              snooze_rise, dismiss_rise;

  btn_edge_detect u_snooze_edge (
    .clock (clock),
    .reset (reset),
    .level (resp_if.snooze_btn),
    .rise  (snooze_rise)
  );

  btn_edge_detect u_dismiss_edge (
    .clock (clock),
    .reset (reset),
    .level (resp_if.dismiss_btn),
    .rise  (dismiss_rise)
  );

  assign ring_inc = ring_cnt_q + RING_W'(1);

  // Next-state decode; button edges win over a same-cycle tick.
  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snz_cnt_d      = snz_cnt_q;
    snooze_count_d = snooze_count_q;
    buzzer_d       = buzzer_q;
    alarm_ack_d    = 1'b0;
    timed_out_d    = 1'b0;
    snoozing_d     = 1'b0;
    case (state_q)
      IDLE: begin
        buzzer_d       = 1'b0;
        snooze_count_d = '0;
        if (resp_if.alarm_ringing) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
          buzzer_d   = 1'b1;
        end
      end
      RINGING: begin
        if (dismiss_rise) begin
          state_d     = HOLDOFF;
          alarm_ack_d = 1'b1;
          buzzer_d    = 1'b0;
        end else if (snooze_rise && (snooze_count_q < SNZ_MAX)) begin
          state_d        = SNOOZE;
          snooze_count_d = snooze_count_q + SC_W'(1);
          snz_cnt_d      = SNZ_LOAD;
          buzzer_d       = 1'b0;
        end else if (!resp_if.alarm_ringing) begin
          state_d        = IDLE;
          buzzer_d       = 1'b0;
          snooze_count_d = '0;
        end else if (resp_if.tick_1hz) begin
          ring_cnt_d = ring_inc;
          if (ring_inc == RING_LIMIT) begin
            state_d     = HOLDOFF;
            timed_out_d = 1'b1;
            buzzer_d    = 1'b0;
          end else begin
            buzzer_d = ~buzzer_q;
          end
        end
      end
      SNOOZE: begin
        buzzer_d = 1'b0;
        if (dismiss_rise) begin
          state_d     = HOLDOFF;
          alarm_ack_d = 1'b1;
        end else if (resp_if.tick_1hz) begin
          // Re-ring when the snooze period expires, whatever the core says.
          if (snz_cnt_q == SNZ_W'(1)) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            buzzer_d   = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q - SNZ_W'(1);
          end
        end
      end
      HOLDOFF: begin
        buzzer_d = 1'b0;
        if (!resp_if.alarm_ringing) begin
          state_d        = IDLE;
          snooze_count_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        buzzer_d = 1'b0;
      end
    endcase
    snoozing_d = (state_d == SNOOZE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ring_cnt_q     <= '0;
      snz_cnt_q      <= '0;
      snooze_count_q <= '0;
      buzzer_q       <= 1'b0;
      snoozing_q     <= 1'b0;
      alarm_ack_q    <= 1'b0;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snz_cnt_q      <= snz_cnt_d;
      snooze_count_q <= snooze_count_d;
      buzzer_q       <= buzzer_d;
      snoozing_q     <= snoozing_d;
      alarm_ack_q    <= alarm_ack_d;
      timed_out_q    <= timed_out_d;
    end
  end

  assign resp_if.buzzer       = buzzer_q;
  assign resp_if.snoozing     = snoozing_q;
  assign resp_if.alarm_ack    = alarm_ack_q;
  assign resp_if.timed_out    = timed_out_q;
  assign resp_if.snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_responder.sv
// tb/tb_alarm_responder.sv - self-checking bench for alarm_responder
module tb_alarm_responder;

  localparam int unsigned SNZ_S = 5;
  localparam int unsigned MAXS  = 3;
  localparam int unsigned RTO   = 60;

  logic clock;
  logic reset;

  alarm_responder_if #(.MAX_SNOOZES(MAXS)) resp_if ();

  alarm_responder #(
    .SNOOZE_SECONDS (SNZ_S),
    .MAX_SNOOZES    (MAXS),
    .RING_TIMEOUT   (RTO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .resp_if (resp_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {buzzer, snoozing, alarm_ack, timed_out, snooze_count[1:0]}
  function automatic logic [5:0] ov(input logic b, input logic s, input logic a,
                                     input logic t, input logic [1:0] c);
    return {b, s, a, t, c};
  endfunction

  function automatic logic [5:0] observed();
    return {resp_if.buzzer, resp_if.snoozing, resp_if.alarm_ack,
            resp_if.timed_out, resp_if.snooze_count};
  endfunction

  // Push expectation for the upcoming edge, clock once, pop and compare.
  task automatic step(input string tag, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, {26'd0, observed()}, {26'd0, e.v});
  endtask

  task automatic tick_step(input string tag, input logic [5:0] v);
    resp_if.tick_1hz = 1'b1;
    step(tag, v);
    resp_if.tick_1hz = 1'b0;
  endtask

  // Five ticks of snooze then re-ring with count c.
  task automatic snooze_out(input string tag, input logic [1:0] c);
    for (int i = 1; i < 5; i++) tick_step({tag, "_snz"}, ov(0, 1, 0, 0, c));
    tick_step({tag, "_rering"}, ov(1, 0, 0, 0, c));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                 = 1'b1;
    resp_if.tick_1hz      = 1'b0;
    resp_if.alarm_ringing = 1'b0;
    resp_if.snooze_btn    = 1'b0;
    resp_if.dismiss_btn   = 1'b0;
    step("reset", ov(0, 0, 0, 0, 0));
    step("reset_hold", ov(0, 0, 0, 0, 0));
    reset = 1'b0;
    step("idle", ov(0, 0, 0, 0, 0));

    // 1: ring, toggle per tick, time out after RTO ticks
    resp_if.alarm_ringing = 1'b1;
    step("ring_start", ov(1, 0, 0, 0, 0));
    for (int k = 1; k <= 60; k++) begin
      if (k < 60) tick_step("ring_tick", ov((k % 2) == 0, 0, 0, 0, 0));
      else        tick_step("timeout", ov(0, 0, 0, 1, 0));
    end
    step("timeout_pulse_end", ov(0, 0, 0, 0, 0));
    step("holdoff_no_retrigger", ov(0, 0, 0, 0, 0));
    resp_if.alarm_ringing = 1'b0;
    step("holdoff_to_idle", ov(0, 0, 0, 0, 0));

    // 2/3: snoozes with re-rings; held snooze across re-ring; 4th ignored
    resp_if.alarm_ringing = 1'b1;
    step("ring2_start", ov(1, 0, 0, 0, 0));
    resp_if.snooze_btn = 1'b1;
    step("snooze1", ov(0, 1, 0, 0, 1));
    resp_if.snooze_btn = 1'b0;
    step("snooze1_hold", ov(0, 1, 0, 0, 1));
    snooze_out("s1", 1);
    resp_if.snooze_btn = 1'b1;
    step("snooze2", ov(0, 1, 0, 0, 2));
    step("snooze2_held", ov(0, 1, 0, 0, 2));
    snooze_out("s2", 2);
    step("held_after_rering", ov(1, 0, 0, 0, 2));
    step("held_after_rering2", ov(1, 0, 0, 0, 2));
    resp_if.snooze_btn = 1'b0;
    step("release", ov(1, 0, 0, 0, 2));
    resp_if.snooze_btn = 1'b1;
    step("snooze3", ov(0, 1, 0, 0, 3));
    resp_if.snooze_btn = 1'b0;
    snooze_out("s3", 3);
    resp_if.snooze_btn = 1'b1;
    step("snooze4_ignored", ov(1, 0, 0, 0, 3));
    resp_if.snooze_btn = 1'b0;
    step("still_ringing", ov(1, 0, 0, 0, 3));

    // 5: dismiss held for 10 cycles -> one ack
    resp_if.dismiss_btn = 1'b1;
    step("dismiss_ack", ov(0, 0, 1, 0, 3));
    for (int i = 1; i < 10; i++) step("dismiss_held", ov(0, 0, 0, 0, 3));
    resp_if.dismiss_btn   = 1'b0;
    resp_if.alarm_ringing = 1'b0;
    step("idle_clear", ov(0, 0, 0, 0, 0));

    // 4: dismiss and snooze in the same cycle
    resp_if.alarm_ringing = 1'b1;
    step("ring3_start", ov(1, 0, 0, 0, 0));
    resp_if.snooze_btn = 1'b1;
    step("ring3_snooze", ov(0, 1, 0, 0, 1));
    resp_if.snooze_btn = 1'b0;
    snooze_out("r3", 1);
    resp_if.snooze_btn  = 1'b1;
    resp_if.dismiss_btn = 1'b1;
    resp_if.tick_1hz    = 1'b1;
    step("both_btn_ack", ov(0, 0, 1, 0, 1));
    resp_if.tick_1hz    = 1'b0;
    resp_if.snooze_btn  = 1'b0;
    resp_if.dismiss_btn = 1'b0;
    step("holdoff_count", ov(0, 0, 0, 0, 1));
    resp_if.alarm_ringing = 1'b0;
    step("idle_count0", ov(0, 0, 0, 0, 0));

    // Dismiss beats a same-cycle tick in SNOOZE
    resp_if.alarm_ringing = 1'b1;
    step("ring4_start", ov(1, 0, 0, 0, 0));
    resp_if.snooze_btn = 1'b1;
    step("ring4_snooze", ov(0, 1, 0, 0, 1));
    resp_if.snooze_btn = 1'b0;
    for (int i = 1; i < 5; i++) tick_step("ring4_snz", ov(0, 1, 0, 0, 1));
    resp_if.dismiss_btn = 1'b1;
    tick_step("snooze_dismiss_vs_tick", ov(0, 0, 1, 0, 1));
    resp_if.dismiss_btn   = 1'b0;
    resp_if.alarm_ringing = 1'b0;
    step("idle_again", ov(0, 0, 0, 0, 0));

    // 6: asynchronous reset mid-SNOOZE
    resp_if.alarm_ringing = 1'b1;
    step("ring5_start", ov(1, 0, 0, 0, 0));
    resp_if.snooze_btn = 1'b1;
    step("ring5_snooze", ov(0, 1, 0, 0, 1));
    resp_if.snooze_btn = 1'b0;
    step("ring5_snz_hold", ov(0, 1, 0, 0, 1));
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset", {26'd0, observed()}, 32'd0);
    step("reset_held", ov(0, 0, 0, 0, 0));
    reset = 1'b0;
    step("ring_after_reset", ov(1, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
